// File: rtl/ppa_result_checker.sv
// Checks a 16-bit adder: queues expected {carry,sum} per operand push and compares on each result pop.
// Latency: compare is combinational on pop; counters and flags update on the same rising edge.
// Backpressure: in_ready drops when the queue is full; pushes while full are dropped and flagged.

module ppa_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             wdat,
    input  logic                     pop,
    output logic [W-1:0]             rdat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    // Generic synchronous FIFO with combinational head read.
    // Latency: a pushed entry is visible at rdat the cycle after push.
    // Backpressure: caller gates push/pop; push on full is legal only with pop.

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;

    assign rdat  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= wdat;
    end
endmodule

module ppa_result_checker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [15:0]              add_1,
    input  logic [15:0]              add_2,
    input  logic                     c_in,
    input  logic                     dut_valid,
    input  logic [15:0]              sum,
    input  logic                     c_out,
    output logic                     in_ready,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err_flag,
    output logic [CNT_W-1:0]         pass_count,
    output logic [CNT_W-1:0]         err_count,
    output logic [16:0]              first_exp,
    output logic [16:0]              first_got,
    output logic                     ovf,
    output logic                     unf,
    output logic [1:0]               state
);
    // Scoreboard checker for a 16-bit adder with sticky error capture and saturating counters.
    // Latency: pop compares against the queue head in-cycle; results register on that edge.
    // Backpressure: in_ready = queue not full; protocol violations latch FAULT until clr.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state_q;
    state_t      state_nxt;
    logic [16:0] exp_dat;
    logic [16:0] got_dat;
    logic [16:0] head_dat;
    logic        q_full;
    logic        q_empty;
    logic        faulted;
    logic        push_vld;
    logic        pop_vld;
    logic        ovf_evt;
    logic        unf_evt;
    logic        match;

    assign exp_dat = {1'b0, add_1} + {1'b0, add_2} + {16'b0, c_in};
    assign got_dat = {c_out, sum};
    assign faulted = (state_q == FAULT);

    // Protocol violations are detected even while faulted so the sticky flags stay truthful.
    assign ovf_evt = in_valid && !dut_valid && q_full;
    assign unf_evt = dut_valid && q_empty;

    // Pop only with data present; a push on full is accepted only alongside a real pop.
    assign pop_vld  = dut_valid && !q_empty && !faulted;
    assign push_vld = in_valid && !faulted && (!q_full || pop_vld);
    assign match    = (head_dat == got_dat);

    ppa_fifo #(
        .DEPTH (DEPTH),
        .W     (17)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push_vld),
        .wdat  (exp_dat),
        .pop   (pop_vld),
        .rdat  (head_dat),
        .count (pending),
        .full  (q_full),
        .empty (q_empty)
    );

    assign in_ready = !q_full;
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (clr) begin
            state_nxt = IDLE;
        end else if (ovf_evt || unf_evt) begin
            state_nxt = FAULT;
        end else begin
            case (state_q)
                IDLE:    if (push_vld && !pop_vld) state_nxt = BUSY;
                BUSY:    if (pop_vld && !push_vld && pending == ($clog2(DEPTH)+1)'(1))
                             state_nxt = IDLE;
                FAULT:   state_nxt = FAULT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_evt) ovf <= 1'b1;
            if (unf_evt) unf <= 1'b1;
        end
    end

    // Counters saturate; the first mismatch alone loads the capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count <= '0;
            err_count  <= '0;
            err_flag   <= 1'b0;
            first_exp  <= '0;
            first_got  <= '0;
        end else if (clr) begin
            pass_count <= '0;
            err_count  <= '0;
            err_flag   <= 1'b0;
            first_exp  <= '0;
            first_got  <= '0;
        end else if (pop_vld) begin
            if (match) begin
                if (pass_count != CNT_MAX) pass_count <= pass_count + CNT_W'(1);
            end else begin
                if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
                err_flag <= 1'b1;
                if (!err_flag) begin
                    first_exp <= head_dat;
                    first_got <= got_dat;
                end
            end
        end
    end
endmodule

// File: tb/tb_ppa_result_checker.sv
// Directed bench for ppa_result_checker with an expected-result scoreboard queue.
module tb_ppa_result_checker;
    localparam int DEPTH = 8;
    localparam int CNT_W = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] add_1;
    logic [15:0] add_2;
    logic        c_in;
    logic        dut_valid;
    logic [15:0] sum;
    logic        c_out;
    logic        in_ready;
    logic [3:0]  pending;
    logic        err_flag;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] err_count;
    logic [16:0] first_exp;
    logic [16:0] first_got;
    logic        ovf;
    logic        unf;
    logic [1:0]  state;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [16:0] sb [$];
    logic [16:0] e;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;

    ppa_result_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .add_1      (add_1),
        .add_2      (add_2),
        .c_in       (c_in),
        .dut_valid  (dut_valid),
        .sum        (sum),
        .c_out      (c_out),
        .in_ready   (in_ready),
        .pending    (pending),
        .err_flag   (err_flag),
        .pass_count (pass_count),
        .err_count  (err_count),
        .first_exp  (first_exp),
        .first_got  (first_got),
        .ovf        (ovf),
        .unf        (unf),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] exp_of(input logic [15:0] a, input logic [15:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {16'b0, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic dv, input logic [16:0] got);
        in_valid  = iv;
        add_1     = a;
        add_2     = b;
        c_in      = ci;
        dut_valid = dv;
        {c_out, sum} = got;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dut_valid = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic ci);
        sb.push_back(exp_of(a, b, ci));
        step(1'b1, a, b, ci, 1'b0, 17'd0);
    endtask

    task automatic push_rand();
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        push(ra, rb, rc);
    endtask

    task automatic pop_match();
        e = sb.pop_front();
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, e);
    endtask

    task automatic pop_val(input string tag, input logic [16:0] v);
        e = sb.pop_front();
        check(tag, 32'(e), 32'(v));
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, v);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        sb.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_pending"}, 32'(pending), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_err_flag"}, 32'(err_flag), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_unf"}, 32'(unf), 0);
        check({tag, "_pass"}, 32'(pass_count), 0);
        check({tag, "_err"}, 32'(err_count), 0);
        check({tag, "_first_exp"}, 32'(first_exp), 0);
        check({tag, "_first_got"}, 32'(first_got), 0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; dut_valid = 1'b0;
        add_1 = '0; add_2 = '0; c_in = 1'b0; sum = '0; c_out = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed adder vectors including carry-out corner.
        push(16'd4322, 16'd7656, 1'b1);
        push(16'd987, 16'd71, 1'b0);
        push(16'd65534, 16'd1, 1'b0);
        push(16'd65534, 16'd1, 1'b1);
        check("vec_pending", 32'(pending), 4);
        check("vec_state_busy", 32'(state), 1);
        pop_val("model_v0", 17'd11979);
        pop_val("model_v1", 17'd1058);
        pop_val("model_v2", 17'd65535);
        pop_val("model_v3", 17'h10000);
        check("vec_pass", 32'(pass_count), 4);
        check("vec_err", 32'(err_count), 0);
        check("vec_state_idle", 32'(state), 0);

        // Mismatch capture, then a second mismatch must not reload capture.
        push(16'd987, 16'd71, 1'b0);
        e = sb.pop_front();
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 17'd1059);
        check("mm_err_flag", 32'(err_flag), 1);
        check("mm_err_count", 32'(err_count), 1);
        check("mm_first_exp", 32'(first_exp), 1058);
        check("mm_first_got", 32'(first_got), 1059);
        check("mm_pass_hold", 32'(pass_count), 4);
        push(16'd1, 16'd1, 1'b0);
        e = sb.pop_front();
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 17'd5);
        check("mm2_err_count", 32'(err_count), 2);
        check("mm2_first_exp", 32'(first_exp), 1058);
        check("mm2_first_got", 32'(first_got), 1059);
        do_clr();
        check_idle("clr1");

        // Fill, overflow into FAULT, frozen behaviour, clr exit.
        for (int i = 0; i < DEPTH; i++) push_rand();
        check("full_in_ready", 32'(in_ready), 0);
        check("full_pending", 32'(pending), 8);
        step(1'b1, 16'd5, 16'd5, 1'b0, 1'b0, 17'd0);
        check("ovf_flag", 32'(ovf), 1);
        check("ovf_state", 32'(state), 2);
        check("ovf_pending", 32'(pending), 8);
        step(1'b1, 16'd1, 16'd2, 1'b0, 1'b1, sb[0]);
        check("fault_pass_frozen", 32'(pass_count), 0);
        check("fault_pending_frozen", 32'(pending), 8);
        check("fault_state_hold", 32'(state), 2);
        do_clr();
        check_idle("clr2");

        // Pop on empty with simultaneous push.
        sb.push_back(exp_of(16'd3, 16'd4, 1'b0));
        step(1'b1, 16'd3, 16'd4, 1'b0, 1'b1, 17'd7);
        check("unf_flag", 32'(unf), 1);
        check("unf_state", 32'(state), 2);
        check("unf_pending", 32'(pending), 1);
        check("unf_pass", 32'(pass_count), 0);
        check("unf_err", 32'(err_count), 0);
        check("unf_ovf", 32'(ovf), 0);
        do_clr();
        check_idle("clr3");

        // Full queue streaming: 20 concurrent push/pop, pointers wrap repeatedly.
        for (int i = 0; i < DEPTH; i++) push_rand();
        for (int i = 0; i < 20; i++) begin
            e = sb.pop_front();
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            sb.push_back(exp_of(ra, rb, rc));
            step(1'b1, ra, rb, rc, 1'b1, e);
        end
        check("stream_pending", 32'(pending), 8);
        check("stream_pass", 32'(pass_count), 20);
        check("stream_ovf", 32'(ovf), 0);
        check("stream_err", 32'(err_count), 0);
        check("stream_state", 32'(state), 1);
        for (int i = 0; i < DEPTH; i++) pop_match();
        check("drain_pass", 32'(pass_count), 28);
        check("drain_state", 32'(state), 0);

        // Saturation at 2^CNT_W-1.
        for (int i = 0; i < 5; i++) begin
            push_rand();
            pop_match();
        end
        check("sat_pass", 32'(pass_count), 31);
        push(16'd10, 16'd20, 1'b0);
        e = sb.pop_front();
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 17'd31);
        check("sat_pass_hold", 32'(pass_count), 31);
        check("sat_err", 32'(err_count), 1);
        check("sat_first_exp", 32'(first_exp), 30);
        do_clr();
        check_idle("clr4");

        // Asynchronous reset mid-operation.
        push_rand();
        push_rand();
        push_rand();
        check("pre_rst_pending", 32'(pending), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push(16'd100, 16'd200, 1'b1);
        check("post_rst_pending", 32'(pending), 1);
        check("post_rst_state", 32'(state), 1);
        pop_match();
        check("post_rst_pass", 32'(pass_count), 1);
        check("post_rst_idle", 32'(state), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
